// File: rtl/ov7670_stream_gen.sv
// OV7670-style QVGA RGB565 pixel-stream generator: background plus a red square at a latched target.
// Define STREAM_GEN_BARS_EN for an 8-colour-bar background; otherwise the background is flat gray.
module ov7670_stream_gen #(
   parameter int unsigned H_ACTIVE    = 320,
   parameter int unsigned V_ACTIVE    = 240,
   parameter int unsigned H_BLANK     = 144,
   parameter int unsigned VSYNC_LINES = 3,
   parameter int unsigned V_BACK      = 17,
   parameter int unsigned V_FRONT     = 10,
   parameter int unsigned BOX_SIZE    = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [9:0]  target_x,
   input  logic [9:0]  target_y,
   output logic        pclk,
   output logic        href,
   output logic        vsync,
   output logic [7:0]  data,
   output logic        frame_done,
   output logic [15:0] frame_cnt
);

   localparam int unsigned LINE_LEN    = 2 * H_ACTIVE + H_BLANK;
   localparam int unsigned FRAME_LINES = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
   localparam int unsigned H_VALID     = 2 * H_ACTIVE;
   localparam int unsigned V_ACT_START = VSYNC_LINES + V_BACK;
   localparam int unsigned V_ACT_END   = V_ACT_START + V_ACTIVE;
   localparam int unsigned HW          = $clog2(LINE_LEN);
   localparam int unsigned VW          = $clog2(FRAME_LINES);
`ifdef STREAM_GEN_BARS_EN
   localparam int unsigned BAR_W       = H_ACTIVE / 8;
`endif

   typedef enum logic [2:0] {
      ST_IDLE, ST_VSYNC, ST_VBACK, ST_ACTIVE, ST_VFRONT
   } state_t;

   state_t          state_q, state_d;
   logic            pclk_q, pclk_d;
   logic [HW-1:0]   h_cnt_q, h_cnt_d;
   logic [VW-1:0]   v_cnt_q, v_cnt_d;
   logic [9:0]      tx_q, tx_d;
   logic [9:0]      ty_q, ty_d;
   logic            href_q, href_d;
   logic            vsync_q, vsync_d;
   logic [7:0]      data_q, data_d;
   logic            frame_done_q, frame_done_d;
   logic [15:0]     frame_cnt_q, frame_cnt_d;

   logic [10:0]     pix_x, pix_y;
   logic            in_box;
   logic [15:0]     bg_pix, pixel;

   // Frame sequencing: everything advances only on the pclk falling edge.
   always_comb begin
      state_d      = state_q;
      pclk_d       = ~pclk_q;
      h_cnt_d      = h_cnt_q;
      v_cnt_d      = v_cnt_q;
      tx_d         = tx_q;
      ty_d         = ty_q;
      frame_done_d = 1'b0;
      frame_cnt_d  = frame_cnt_q;
      if (pclk_q) begin
         if (state_q == ST_IDLE) begin
            if (enable) begin
               state_d = ST_VSYNC;
               h_cnt_d = '0;
               v_cnt_d = '0;
               tx_d    = target_x;
               ty_d    = target_y;
            end
         end else if (h_cnt_q != HW'(LINE_LEN - 1)) begin
            h_cnt_d = h_cnt_q + HW'(1);
         end else begin
            h_cnt_d = '0;
            if (v_cnt_q == VW'(FRAME_LINES - 1)) begin
               v_cnt_d      = '0;
               frame_done_d = 1'b1;
               frame_cnt_d  = frame_cnt_q + 16'd1;
               if (enable) begin
                  state_d = ST_VSYNC;
                  tx_d    = target_x;
                  ty_d    = target_y;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               v_cnt_d = v_cnt_q + VW'(1);
               if (v_cnt_d == VW'(VSYNC_LINES))      state_d = ST_VBACK;
               else if (v_cnt_d == VW'(V_ACT_START)) state_d = ST_ACTIVE;
               else if (v_cnt_d == VW'(V_ACT_END))   state_d = ST_VFRONT;
            end
         end
      end
   end

   // Pixel colour for the coordinate about to be transmitted; 11-bit compare avoids wrap.
   always_comb begin
      pix_x  = 11'(h_cnt_d[HW-1:1]);
      pix_y  = 11'(v_cnt_d) - 11'(V_ACT_START);
      in_box = (pix_x >= {1'b0, tx_q}) && (pix_x <= {1'b0, tx_q} + 11'(BOX_SIZE - 1)) &&
               (pix_y >= {1'b0, ty_q}) && (pix_y <= {1'b0, ty_q} + 11'(BOX_SIZE - 1));
`ifdef STREAM_GEN_BARS_EN
      case (3'(pix_x / 11'(BAR_W)))
         3'd0:    bg_pix = 16'hFFFF;
         3'd1:    bg_pix = 16'hFFE0;
         3'd2:    bg_pix = 16'h07FF;
         3'd3:    bg_pix = 16'h07E0;
         3'd4:    bg_pix = 16'hF81F;
         3'd5:    bg_pix = 16'hF800;
         3'd6:    bg_pix = 16'h001F;
         default: bg_pix = 16'h0000;
      endcase
`else
      bg_pix = 16'h8410;
`endif
      pixel = in_box ? 16'hF800 : bg_pix;
   end

   // Line/frame sync and data bytes, high byte on even h_cnt.
   always_comb begin
      vsync_d = vsync_q;
      href_d  = href_q;
      data_d  = data_q;
      if (pclk_q) begin
         vsync_d = (state_d == ST_VSYNC);
         href_d  = (state_d == ST_ACTIVE) && (h_cnt_d < HW'(H_VALID));
         data_d  = href_d ? (h_cnt_d[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         pclk_q       <= 1'b0;
         h_cnt_q      <= '0;
         v_cnt_q      <= '0;
         tx_q         <= '0;
         ty_q         <= '0;
         href_q       <= 1'b0;
         vsync_q      <= 1'b0;
         data_q       <= 8'h00;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= 16'd0;
      end else begin
         state_q      <= state_d;
         pclk_q       <= pclk_d;
         h_cnt_q      <= h_cnt_d;
         v_cnt_q      <= v_cnt_d;
         tx_q         <= tx_d;
         ty_q         <= ty_d;
         href_q       <= href_d;
         vsync_q      <= vsync_d;
         data_q       <= data_d;
         frame_done_q <= frame_done_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign pclk       = pclk_q;
   assign href       = href_q;
   assign vsync      = vsync_q;
   assign data       = data_q;
   assign frame_done = frame_done_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Scoreboard bench for ov7670_stream_gen on a shrunken frame geometry.
module tb_ov7670_stream_gen;

   localparam int unsigned HA = 16, VA = 12, HB = 6, VS = 2, VB = 3, VF = 2, BOX = 4;
   localparam int unsigned LINE      = 2 * HA + HB;
   localparam int unsigned FL        = VS + VB + VA + VF;
   localparam int unsigned FRAME_CLK = 2 * LINE * FL;

   logic        clk = 1'b0;
   logic        reset, enable;
   logic [9:0]  target_x, target_y;
   logic        pclk, href, vsync, frame_done;
   logic [7:0]  data;
   logic [15:0] frame_cnt;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int fd_count = 0;
   logic [7:0] sb[$];

   ov7670_stream_gen #(
      .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .VSYNC_LINES(VS),
      .V_BACK(VB), .V_FRONT(VF), .BOX_SIZE(BOX)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .target_x(target_x), .target_y(target_y),
      .pclk(pclk), .href(href), .vsync(vsync), .data(data),
      .frame_done(frame_done), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] bg(input int x);
`ifdef STREAM_GEN_BARS_EN
      case (x / (HA / 8))
         0: return 16'hFFFF;
         1: return 16'hFFE0;
         2: return 16'h07FF;
         3: return 16'h07E0;
         4: return 16'hF81F;
         5: return 16'hF800;
         6: return 16'h001F;
         default: return 16'h0000;
      endcase
`else
      return 16'h8410;
`endif
   endfunction

   function automatic logic [15:0] exp_pix(input int x, input int y, input int tx, input int ty);
      if (x >= tx && x < tx + BOX && y >= ty && y < ty + BOX) return 16'hF800;
      return bg(x);
   endfunction

   task automatic push_frame(input int tx, input int ty);
      logic [15:0] p;
      for (int y = 0; y < VA; y++)
         for (int x = 0; x < HA; x++) begin
            p = exp_pix(x, y, tx, ty);
            sb.push_back(p[15:8]);
            sb.push_back(p[7:0]);
         end
   endtask

   task automatic wait_fd(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_done && n < FRAME_CLK + 200);
      check(tag, 32'(frame_done), 32'd1);
   endtask

   // Protocol monitor: pulse widths, sync lengths and byte stream, sampled after each pclk rise.
   logic vs_prev, hr_prev;
   int   vs_run, hr_run, lo_run, pulses;
   always @(negedge clk) begin
      if (reset) begin
         vs_prev = 1'b0; hr_prev = 1'b0;
         vs_run = 0; hr_run = 0; lo_run = 0; pulses = 0;
      end else begin
         if (frame_done) begin
            check("href_pulses", 32'(pulses), 32'(VA));
            pulses = 0;
            fd_count++;
         end
         if (pclk) begin
            if (vsync) vs_run++;
            else if (vs_prev) begin
               check("vsync_len", 32'(vs_run), 32'(VS * LINE));
               vs_run = 0;
            end
            if (href) begin
               if (!hr_prev) begin
                  if (pulses > 0) check("href_low", 32'(lo_run), 32'(HB));
                  pulses++;
               end
               hr_run++;
               if (sb.size() == 0) check("sb_empty", 32'(sb.size()), 32'd1);
               else check("pix_byte", 32'(data), 32'(sb.pop_front()));
            end else begin
               if (hr_prev) begin
                  check("href_high", 32'(hr_run), 32'(2 * HA));
                  hr_run = 0;
                  lo_run = 0;
               end
               lo_run++;
               check("data_blank", 32'(data), 32'd0);
            end
            vs_prev = vsync;
            hr_prev = href;
         end
      end
   end

   initial begin
      int t_vs, fd_before;
      logic busy;
      reset = 1'b1; enable = 1'b1; target_x = 10'd5; target_y = 10'd3;
      repeat (5) begin
         @(negedge clk);
         check("rst_outs", 32'({pclk, href, vsync, data, frame_done, frame_cnt}), 32'd0);
      end
      push_frame(5, 3);
      reset = 1'b0;
      @(negedge clk);
      check("clk1_pclk", 32'(pclk), 32'd1);
      check("clk1_vsync", 32'(vsync), 32'd0);
      @(negedge clk);
      check("clk2_pclk", 32'(pclk), 32'd0);
      check("clk2_vsync", 32'(vsync), 32'd1);
      t_vs = cyc;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("pclk_toggle", 32'(pclk), (i % 2 == 0) ? 32'd1 : 32'd0);
      end

      // Frame 2 targets set mid-frame 1: edge clipping.
      repeat (100) @(negedge clk);
      target_x = 10'd14; target_y = 10'd10;
      push_frame(14, 10);
      wait_fd("fd1");
      check("frame_period", 32'(cyc - t_vs), 32'(FRAME_CLK));
      check("frame_cnt1", 32'(frame_cnt), 32'd1);
      check("sb_after_f1", 32'(sb.size()), 32'(2 * HA * VA));

      repeat (100) @(negedge clk);
      target_x = 10'd0; target_y = 10'd0;
      push_frame(0, 0);
      wait_fd("fd2");
      check("frame_cnt2", 32'(frame_cnt), 32'd2);

      // Drop enable and change targets mid-frame 3; the frame must finish unchanged.
      repeat (2 * LINE * (VS + VB + 5)) @(negedge clk);
      enable = 1'b0; target_x = 10'd9; target_y = 10'd9;
      wait_fd("fd3");
      check("frame_cnt3", 32'(frame_cnt), 32'd3);
      check("sb_after_f3", 32'(sb.size()), 32'd0);
      busy = 1'b0;
      repeat (4 * LINE) begin
         @(negedge clk);
         if (vsync || href || data != 8'h00 || frame_done) busy = 1'b1;
      end
      check("idle_quiet", 32'(busy), 32'd0);
      check("idle_fd_count", 32'(fd_count), 32'd3);

      // Restart, then abort with reset partway into the active region.
      target_x = 10'd2; target_y = 10'd2;
      push_frame(2, 2);
      enable = 1'b1;
      repeat (2 * LINE * (VS + VB + 2) + 10) @(negedge clk);
      check("abort_in_active", 32'(sb.size() < 2 * HA * VA), 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      sb.delete();
      fd_before = fd_count;
      @(negedge clk);
      @(negedge clk);
      check("abort_outs", 32'({href, vsync, data, frame_done, frame_cnt}), 32'd0);
      check("abort_pclk", 32'(pclk), 32'd0);
      repeat (20) @(negedge clk);
      reset = 1'b0; enable = 1'b0;
      repeat (4 * LINE) @(negedge clk);
      check("abort_no_fd", 32'(fd_count), 32'(fd_before));
      check("abort_cnt", 32'(frame_cnt), 32'd0);
      check("abort_idle", 32'({vsync, href}), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ov7670_stream_gen.md
# ov7670_stream_gen

Synthesizable OV7670 pixel-stream transmitter: the camera-side end of the interface that `OV7670_controller` receives. It emits `pclk`/`href`/`vsync`/`data` in QVGA RGB565 format, two bytes per pixel with the high byte first. The image is a background pattern plus a solid red square at a runtime-selectable position. It replaces the physical camera in simulation and board bring-up, so the frame-buffer, VGA and `red_tracker` path can run with known coordinates.

## Interface
- H_ACTIVE, 320, pixels per line
- V_ACTIVE, 240, active lines per frame
- H_BLANK, 144, pclk periods with href low after each line's active bytes
- VSYNC_LINES, 3, line periods with vsync high
- V_BACK, 17, idle lines after vsync
- V_FRONT, 10, idle lines after the last active line
- BOX_SIZE, 32, red square edge length in pixels
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  stream enable; sampled only at frame start
- target_x  in  10  square left column
- target_y  in  10  square top line
- pclk  out  1  pixel clock, clk/2
- href  out  1  line-valid
- vsync  out  1  frame sync, active high
- data  out  8  pixel byte
- frame_done  out  1  one-clk pulse at the end of each transmitted frame
- frame_cnt  out  16  count of completed frames, wraps

## Operation
- Reset sets these outputs to 0: pclk, href, vsync, data, frame_done, frame_cnt. Counters clear. State is IDLE.
- pclk is a toggle register and is free-running in every state.
- All other outputs and counters update only on the clk edge where pclk falls (pclk_q==1). They are stable at the next pclk rising edge.
- Counters:
  - h_cnt runs 0..LINE_LEN-1, with LINE_LEN = 2*H_ACTIVE + H_BLANK = 784.
  - v_cnt runs 0..FRAME_LINES-1, with FRAME_LINES = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT = 270.
- FSM states: IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
  - IDLE: leaves on a pclk fall with enable=1. Enters VSYNC with h_cnt=v_cnt=0 and latches target_x/target_y into shadow registers.
  - VSYNC→VBACK after VSYNC_LINES lines. VBACK→ACTIVE after V_BACK lines. ACTIVE→VFRONT after V_ACTIVE lines.
  - At the end of VFRONT, frame_done pulses, frame_cnt increments, and enable is sampled. If enable=1, the FSM goes to VSYNC and re-latches the targets. If enable=0, it goes to IDLE.
- vsync=1 throughout VSYNC.
- href=1 in ACTIVE while h_cnt < 2*H_ACTIVE.
- Pixel coordinates: x = h_cnt>>1; y = line index within ACTIVE.
  - h_cnt[0]=0 sends pixel[15:8]; h_cnt[0]=1 sends pixel[7:0].
- Pixel value:
  - Inside the square: 16'hF800. The inside test is x in [tx, tx+BOX_SIZE-1] and y in [ty, ty+BOX_SIZE-1], compared in 11 bits so there is no wrap. The square clips at the frame edge.
  - Otherwise: the background pattern (see Configuration).
- data=0 whenever href=0.
- enable deasserted mid-frame has no effect until the frame ends. target changes mid-frame have no effect until the next frame latch.
- reset asserted mid-frame returns to IDLE immediately with all outputs 0. No frame_done is issued for the aborted frame.

## Timing
- pclk period = 2 clk. Data changes on the pclk falling edge and is captured on the rising edge, so there is 1 clk of setup.
- From reset release with enable=1:
  - first pclk rise on clk 1;
  - vsync rises at the first pclk fall (clk 2);
  - first href rise after (VSYNC_LINES+V_BACK)*LINE_LEN pclk periods.
- Line: href high for 640 pclk, then low for 144 pclk.
- Frame: 270*784 = 211680 pclk = 423360 clk.
- frame_done is high for 1 clk, on the edge that starts the next VSYNC or IDLE. frame_cnt updates on the same edge.

## Configuration
- `STREAM_GEN_BARS_EN` defined: the background is 8 vertical colour bars, each H_ACTIVE/8 = 40 px wide, in this order:
  - 0 white FFFF
  - 1 yellow FFE0
  - 2 cyan 07FF
  - 3 green 07E0
  - 4 magenta F81F
  - 5 red F800
  - 6 blue 001F
  - 7 black 0000
- `STREAM_GEN_BARS_EN` undefined: the background is flat gray 8410. In this mode the square is the only red in the frame, which is the mode used for tracker tests.

## Test plan
- Reset held for 5 clk, then released with enable=1 → all outputs 0 during reset. pclk toggles every clk after release. vsync is high for exactly 3*784 pclk rises.
- Line timing → each ACTIVE line shows exactly 640 href-high pclk rises followed by 144 low. There are 240 href pulses per frame. frame_done pulses once and frame_cnt goes 0→1 after 211680 pclk.
- Bars off, target=(100,50):
  - pixel (100,50) bytes are F8,00; pixel (131,81) bytes are F8,00;
  - pixel (132,81) and (99,50) bytes are 84,10.
- Edge clipping, target=(300,230) → pixels x 300..319 on lines 230..239 are red. There is no red on lines 0..21, which rules out wrap.
- Bars on → x=0 gives FF,FF; x=200 gives F8,00; x=319 gives 00,00.
- enable dropped on line 100, then reset mid-frame:
  - the frame completes, frame_done pulses, and the FSM enters IDLE with vsync/href staying 0;
  - with enable=1 re-applied and reset asserted on line 50, all outputs are 0 on the next clk and no frame_done is issued.
